rr_arb_dreg: RTL and testbench
==============================

Name: rr_arb_dreg

Overview:
- N-input round-robin arbiter merging N valid/ready streams onto one output.
- The output passes through a single registered output stage: 1-cycle latency, full throughput.
- Optional packet lock holds the grant on one input until its end-of-transaction beat.
- Sits in front of shared downstream resources (one consumer, many producers) in the gear datapath.

Parameters:
- N, 4: number of input streams; legal range 2..16.
- DIN, 16: data width per input, in bits.
- LOCK, 0: 1 = grant is held until a beat with eot (bit DIN-1) = 1 transfers. 0 = re-arbitrate every beat.
- INIT_PTR, 0: round-robin pointer value after reset; legal range 0..N-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- din_data  in  N*DIN  input data; input i occupies bits [i*DIN +: DIN].
- din_valid  in  N  per-input valid.
- din_ready  out  N  per-input ready.
- dout_data  out  DIN  registered output data.
- dout_idx  out  $clog2(N)  index of the input that produced the current dout_data.
- dout_valid  out  1  registered output valid.
- dout_ready  in  1  downstream ready.

Behaviour:
- Reset values (sync, active-high rst sampled at posedge clk):
  - dout_valid = 0; dout_data and dout_idx are don't-care.
  - ptr = INIT_PTR; locked = 0; lock_idx = 0.
- Output stage:
  - reg_ready = !dout_valid | dout_ready.
  - dout_* are driven directly from registers. There is no combinational path from din_* to dout_*.
- Grant (combinational, evaluated every cycle):
  - If locked: grant = lock_idx if din_valid[lock_idx], else no grant. Other inputs are ignored even if valid.
  - Otherwise: grant = first i with din_valid[i], searching i = ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap modulo N).
  - No valid input gives no grant.
- din_ready[i] = reg_ready & (grant == i). At most one din_ready bit is high per cycle. din_ready may depend combinationally on dout_ready and on din_valid.
- Transfer on input g (din_valid[g] & din_ready[g]) at a posedge:
  - dout_data <= din_data[g]; dout_idx <= g; dout_valid <= 1.
  - ptr <= (g+1) mod N.
  - If LOCK=1: locked <= !eot, where eot = din_data[g*DIN + DIN-1]; lock_idx <= g.
- reg_ready = 1 with no grant: dout_valid <= 0; ptr and lock state unchanged.
- reg_ready = 0: all registers hold. din_ready = 0 for all inputs.
- Simultaneous output drain and input load in the same cycle (dout_valid & dout_ready & grant present): the new beat is loaded, dout_valid stays 1, giving full throughput.
- Locked and the locked input is idle: the output drains, nothing else is granted, and the lock persists until the eot beat transfers.
- LOCK=0: locked is never set. Bit DIN-1 is ordinary data.
- Reset mid-packet or mid-stall: the held beat is discarded (dout_valid = 0), the lock is cleared, ptr = INIT_PTR. Upstream is responsible for re-sending.
- Inputs must hold data stable while valid and not ready. The block does not check this.

Test Plan:
- Single input:
  - Stimulus: N=4, DIN=16, only din_valid[2]=1 with data 0x1234, dout_ready=1.
  - Required: next cycle dout_valid=1, dout_data=0x1234, dout_idx=2; din_ready=4'b0100 every cycle; one beat per cycle sustained.
- Round-robin fairness:
  - Stimulus: all four inputs continuously valid with data 0x000i, dout_ready=1, INIT_PTR=0.
  - Required: dout_idx sequence 0,1,2,3,0,1,... with no bubbles.
- Backpressure:
  - Stimulus: inputs 1 and 3 valid, dout_ready=0 for 5 cycles after the first beat.
  - Required: dout holds (idx=1) for 5 cycles; din_ready=0 throughout; on release, the next beat is idx=3 in the same cycle dout_ready rises.
- Lock:
  - Stimulus: LOCK=1, DIN=16. Input 0 sends 3 beats 0x0001, 0x0002, 0x8003 (eot on the last); input 1 is valid throughout.
  - Required: dout_idx=0,0,0, then 1; input 1 is never granted before the 0x8003 transfer.
- Lock with idle holder:
  - Stimulus: LOCK=1. Input 0 sends 0x0001, then deasserts valid for 3 cycles; input 2 is valid.
  - Required: dout_valid=0 for those cycles and input 2 is not granted; after input 0 sends 0x8002, input 2 is granted.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while locked and dout_valid=1.
  - Required: next cycle dout_valid=0, lock cleared, ptr=INIT_PTR. With inputs 1 and 2 valid, input 1 is granted first.

Source files
------------

// File: rtl/rr_arb_dreg.sv
// rtl/rr_arb_dreg.sv - N-input round-robin arbiter with registered output stage and optional packet lock
module rr_arb_dreg #(
  parameter int N        = 4,
  parameter int DIN      = 16,
  parameter int LOCK     = 0,
  parameter int INIT_PTR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*DIN-1:0]      din_data,
  input  logic [N-1:0]          din_valid,
  output logic [N-1:0]          din_ready,
  output logic [DIN-1:0]        dout_data,
  output logic [$clog2(N)-1:0]  dout_idx,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int IW = $clog2(N);

  logic [IW-1:0]  ptr;
  logic           locked;
  logic [IW-1:0]  lock_idx;

  logic           reg_ready;
  logic           grant_vld;
  logic [IW-1:0]  grant_idx;
  logic [IW:0]    cand;
  logic [DIN-1:0] sel_data;
  logic [IW-1:0]  ptr_next;
  logic           load;

  // Output register can accept a beat when empty or draining this cycle
  always_comb begin
    reg_ready = !dout_valid || dout_ready;
  end

  // Grant selection: locked holder only, else first valid input at or after ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (locked) begin
      grant_vld = din_valid[lock_idx];
      grant_idx = lock_idx;
    end else begin
      // Walk from the farthest candidate back to ptr so the nearest one wins
      for (int k = N - 1; k >= 0; k--) begin
        cand = {1'b0, ptr} + (IW + 1)'(k);
        if (cand >= (IW + 1)'(N)) begin
          cand = cand - (IW + 1)'(N);
        end
        if (din_valid[cand[IW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[IW-1:0];
        end
      end
    end
  end

  // Data mux for the granted input
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_data = din_data[i*DIN +: DIN];
      end
    end
  end

  // One-hot ready back to the granted input only while the output can load
  always_comb begin
    din_ready = '0;
    for (int i = 0; i < N; i++) begin
      din_ready[i] = reg_ready && grant_vld && (grant_idx == IW'(i));
    end
  end

  // Next round-robin pointer: one past the input just served, wrapping at N
  always_comb begin
    if (grant_idx == IW'(N - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + 1'b1;
    end
    load = reg_ready && grant_vld;
  end

  // Output stage, pointer and lock state
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      ptr        <= IW'(INIT_PTR);
      locked     <= 1'b0;
      lock_idx   <= '0;
    end else if (load) begin
      dout_data  <= sel_data;
      dout_idx   <= grant_idx;
      dout_valid <= 1'b1;
      ptr        <= ptr_next;
      if (LOCK != 0) begin
        // Stay on this input until a beat carrying end-of-transaction moves
        locked   <= !sel_data[DIN-1];
        lock_idx <= grant_idx;
      end
    end else if (reg_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_dreg.sv
// tb/tb_rr_arb_dreg.sv - directed table-driven bench for rr_arb_dreg (LOCK=0 and LOCK=1 instances)
module tb_rr_arb_dreg;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  v0, v1;
  logic [63:0] d0, d1;
  logic        r0, r1;
  logic [3:0]  rdy0, rdy1;
  logic [15:0] od0, od1;
  logic [1:0]  oi0, oi1;
  logic        ov0, ov1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          pre_rst;
    logic [3:0]  valid;
    logic [63:0] data;
    bit          rdy;
    logic [3:0]  exp_ready;
    bit          exp_ov;
    logic [1:0]  exp_idx;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_arb_dreg #(.N(4), .DIN(16), .LOCK(0), .INIT_PTR(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .din_data   (d0),
    .din_valid  (v0),
    .din_ready  (rdy0),
    .dout_data  (od0),
    .dout_idx   (oi0),
    .dout_valid (ov0),
    .dout_ready (r0)
  );

  rr_arb_dreg #(.N(4), .DIN(16), .LOCK(1), .INIT_PTR(0)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .din_data   (d1),
    .din_valid  (v1),
    .din_ready  (rdy1),
    .dout_data  (od1),
    .dout_idx   (oi1),
    .dout_valid (ov1),
    .dout_ready (r1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic add(input bit pr, input logic [3:0] v, input logic [63:0] d, input bit rdy,
                     input logic [3:0] er, input bit eov, input logic [1:0] ei, input logic [15:0] ed);
    vec_t t;
    t.pre_rst = pr; t.valid = v; t.data = d; t.rdy = rdy;
    t.exp_ready = er; t.exp_ov = eov; t.exp_idx = ei; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1; v0 = '0; v1 = '0; r0 = 1'b1; r1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst ov0", {31'b0, ov0}, 32'd0);
    chk("rst ov1", {31'b0, ov1}, 32'd0);
  endtask

  task automatic cyc0(input string nm, input logic [3:0] v, input logic [63:0] d, input bit rdy,
                      input logic [3:0] er, input bit eov, input logic [1:0] ei, input logic [15:0] ed);
    v0 = v; d0 = d; r0 = rdy;
    #1;
    chk({nm, " din_ready"}, {28'b0, rdy0}, {28'b0, er});
    @(posedge clk); #1;
    chk({nm, " dout_valid"}, {31'b0, ov0}, {31'b0, eov});
    if (eov) begin
      chk({nm, " dout_idx"}, {30'b0, oi0}, {30'b0, ei});
      chk({nm, " dout_data"}, {16'b0, od0}, {16'b0, ed});
    end
  endtask

  task automatic cyc1(input string nm, input logic [3:0] v, input logic [63:0] d, input bit rdy,
                      input logic [3:0] er, input bit eov, input logic [1:0] ei, input logic [15:0] ed);
    v1 = v; d1 = d; r1 = rdy;
    #1;
    chk({nm, " din_ready"}, {28'b0, rdy1}, {28'b0, er});
    @(posedge clk); #1;
    chk({nm, " dout_valid"}, {31'b0, ov1}, {31'b0, eov});
    if (eov) begin
      chk({nm, " dout_idx"}, {30'b0, oi1}, {30'b0, ei});
      chk({nm, " dout_data"}, {16'b0, od1}, {16'b0, ed});
    end
  endtask

  // One-cycle reset while the LOCK=1 instance is stalled and holding a locked beat
  task automatic mid_reset(input logic [3:0] v, input logic [63:0] d);
    rst = 1'b1; r1 = 1'b0; v1 = v; d1 = d;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst ov1", {31'b0, ov1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; v0 = '0; v1 = '0; d0 = '0; d1 = '0; r0 = 1'b1; r1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset ov0", {31'b0, ov0}, 32'd0);
    chk("reset ov1", {31'b0, ov1}, 32'd0);

    // Single input, sustained; bit 15 is plain data when LOCK=0
    add(0, 4'b0100, {16'h0, 16'h1234, 16'h0, 16'h0}, 1, 4'b0100, 1, 2'd2, 16'h1234);
    add(0, 4'b0100, {16'h0, 16'h1235, 16'h0, 16'h0}, 1, 4'b0100, 1, 2'd2, 16'h1235);
    add(0, 4'b0100, {16'h0, 16'h9236, 16'h0, 16'h0}, 1, 4'b0100, 1, 2'd2, 16'h9236);
    add(0, 4'b0000, 64'h0, 1, 4'b0000, 0, 2'd0, 16'h0);
    // Fairness, all inputs valid, no bubbles
    for (int i = 0; i < 8; i++) begin
      add(i == 0, 4'b1111, {16'h3, 16'h2, 16'h1, 16'h0}, 1, 4'(1 << (i % 4)), 1,
          2'(i % 4), 16'(i % 4));
    end
    // Backpressure: hold idx 1 for 5 cycles, then idx 3 in the release cycle
    add(1, 4'b1010, {16'h0033, 16'h0, 16'h0011, 16'h0}, 1, 4'b0010, 1, 2'd1, 16'h0011);
    for (int i = 0; i < 5; i++) begin
      add(0, 4'b1010, {16'h0033, 16'h0, 16'h0011, 16'h0}, 0, 4'b0000, 1, 2'd1, 16'h0011);
    end
    add(0, 4'b1010, {16'h0033, 16'h0, 16'h0011, 16'h0}, 1, 4'b1000, 1, 2'd3, 16'h0033);
    add(0, 4'b1010, {16'h0033, 16'h0, 16'h0011, 16'h0}, 1, 4'b0010, 1, 2'd1, 16'h0011);
    // Empty register loads even with dout_ready low, then holds
    add(0, 4'b0000, 64'h0, 1, 4'b0000, 0, 2'd0, 16'h0);
    add(0, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0044}, 0, 4'b0001, 1, 2'd0, 16'h0044);
    add(0, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0045}, 0, 4'b0000, 1, 2'd0, 16'h0044);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) do_reset();
      cyc0($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].rdy,
           vecs[i].exp_ready, vecs[i].exp_ov, vecs[i].exp_idx, vecs[i].exp_data);
    end
    v0 = '0;

    // Lock: input 0 keeps the grant until 0x8003 even though ptr moved to 1
    do_reset();
    cyc1("lock_b0", 4'b0011, {16'h0, 16'h0, 16'h0100, 16'h0001}, 1, 4'b0001, 1, 2'd0, 16'h0001);
    cyc1("lock_b1", 4'b0011, {16'h0, 16'h0, 16'h0100, 16'h0002}, 1, 4'b0001, 1, 2'd0, 16'h0002);
    cyc1("lock_b2", 4'b0011, {16'h0, 16'h0, 16'h0100, 16'h8003}, 1, 4'b0001, 1, 2'd0, 16'h8003);
    cyc1("lock_next", 4'b0010, {16'h0, 16'h0, 16'h0100, 16'h0}, 1, 4'b0010, 1, 2'd1, 16'h0100);

    // Lock with idle holder: output drains, input 2 waits
    do_reset();
    cyc1("idle_b0", 4'b0101, {16'h0, 16'h0200, 16'h0, 16'h0001}, 1, 4'b0001, 1, 2'd0, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      cyc1($sformatf("idle_gap%0d", i), 4'b0100, {16'h0, 16'h0200, 16'h0, 16'h0}, 1,
           4'b0000, 0, 2'd0, 16'h0);
    end
    cyc1("idle_eot", 4'b0101, {16'h0, 16'h0200, 16'h0, 16'h8002}, 1, 4'b0001, 1, 2'd0, 16'h8002);
    cyc1("idle_after", 4'b0100, {16'h0, 16'h0200, 16'h0, 16'h0}, 1, 4'b0100, 1, 2'd2, 16'h0200);

    // Reset while locked on input 1 and stalled: lock must be gone afterwards
    do_reset();
    cyc1("rst_setup", 4'b0010, {16'h0, 16'h0, 16'h0005, 16'h0}, 1, 4'b0010, 1, 2'd1, 16'h0005);
    mid_reset(4'b0110, {16'h0, 16'h0022, 16'h0011, 16'h0});
    cyc1("rst_lockclr", 4'b0100, {16'h0, 16'h0022, 16'h0, 16'h0}, 1, 4'b0100, 1, 2'd2, 16'h0022);

    // Reset after ptr advanced to 2: ptr returns to 0, input 1 wins over 2
    do_reset();
    cyc1("rst_setup2", 4'b0010, {16'h0, 16'h0, 16'h0005, 16'h0}, 1, 4'b0010, 1, 2'd1, 16'h0005);
    mid_reset(4'b0110, {16'h0, 16'h0022, 16'h8011, 16'h0});
    cyc1("rst_ptr", 4'b0110, {16'h0, 16'h8022, 16'h8011, 16'h0}, 1, 4'b0010, 1, 2'd1, 16'h8011);
    cyc1("rst_next", 4'b0110, {16'h0, 16'h8022, 16'h8011, 16'h0}, 1, 4'b0100, 1, 2'd2, 16'h8022);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
